cache_mem_arbiter: RTL and testbench

//  Shares the single unified main-memory port between the I-cache fill path and the D-cache fill/writeback path.

---
 rtl/cache_mem_arbiter_if.sv | 34 +++
 rtl/cache_mem_arbiter.sv | 115 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and memory-side signal bundle for the memory arbiter
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Surrounding system side (caches and memory)
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one fixed-latency memory port between I-cache and D-cache
module cache_mem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  cache_mem_arbiter_if.slave arb
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_d_q;
  logic              win_d_q;
  logic              drop_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic grant_d;
  logic grant_i;
  logic in_acc;
  logic last_acc;
  logic win_req;

  // D has priority unless it was served last and I is also waiting
  assign grant_d  = arb.d_req && (!arb.i_req || !last_d_q);
  assign grant_i  = arb.i_req && !grant_d;
  assign in_acc   = (state_q == I_ACC) || (state_q == D_ACC);
  assign last_acc = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign win_req  = win_d_q ? arb.d_req : arb.i_req;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = D_ACC;
        else if (grant_i) state_d = I_ACC;
      end
      I_ACC, D_ACC: if (last_acc) state_d = RESP;
      RESP:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Grant latching, access counting, read capture and fairness bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      win_d_q     <= 1'b0;
      drop_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d || grant_i) begin
            win_d_q     <= grant_d;
            mem_we_q    <= grant_d && arb.d_we;
            mem_addr_q  <= grant_d ? arb.d_addr : arb.i_addr;
            mem_wdata_q <= grant_d ? arb.d_wdata : '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
          end
        end
        I_ACC, D_ACC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A withdrawn request still lets the memory op finish, but kills the ack
          if (!win_req) drop_q <= 1'b1;
          if (last_acc) begin
            if (win_d_q) d_rdata_q <= arb.mem_rdata;
            else         i_rdata_q <= arb.mem_rdata;
          end
        end
        RESP: begin
          if (!drop_q) last_d_q <= win_d_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    arb.busy   = (state_q != IDLE);
    arb.mem_en = in_acc;
    arb.mem_we = in_acc && mem_we_q;
    arb.i_ack  = (state_q == RESP) && !win_d_q && !drop_q;
    arb.d_ack  = (state_q == RESP) &&  win_d_q && !drop_q;
  end

  assign arb.mem_addr  = mem_addr_q;
  assign arb.mem_wdata = mem_wdata_q;
  assign arb.i_rdata   = i_rdata_q;
  assign arb.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cache_mem_arbiter_if #(.ADDR_W(14), .DATA_W(64)) bus ();

  cache_mem_arbiter #(.ADDR_W(14), .DATA_W(64), .MEM_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple memory model: combinational read while enabled, write on each enabled edge
  logic [63:0] mem [0:255];
  assign bus.mem_rdata = bus.mem_en ? mem[bus.mem_addr[7:0]] : 64'h0;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next ack; cyc stays 0 on timeout
  task automatic wait_ack(output int cyc, output logic got_i, output logic got_d,
                          output int we_cnt, output logic overlap);
    cyc = 0; got_i = 1'b0; got_d = 1'b0; we_cnt = 0; overlap = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.mem_we) we_cnt++;
      if (bus.i_ack && bus.d_ack) overlap = 1'b1;
      if (bus.i_ack || bus.d_ack) begin
        cyc   = k;
        got_i = bus.i_ack;
        got_d = bus.d_ack;
        break;
      end
    end
  endtask

  int   cyc;
  int   we_cnt;
  int   acks;
  logic got_i, got_d, overlap;
  logic busy5, busy6;

  initial begin
    checks = 0;
    failures = 0;
    for (int a = 0; a < 256; a++) mem[a] = 64'h0;
    mem[8'h10] = 64'h0001_0002_0003_0004;
    mem[8'h20] = 64'h1111_2222_3333_4444;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", {63'h0, bus.busy}, 64'h0);
    chk("rst_mem_en", {63'h0, bus.mem_en}, 64'h0);
    chk("rst_acks", {62'h0, bus.i_ack, bus.d_ack}, 64'h0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 64'h0);
    rst = 1'b0;

    // Test 1: I read
    bus.i_req = 1'b1; bus.i_addr = 14'h0010;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t1_latency", 64'(cyc), 64'd5);
    chk("t1_who", {62'h0, got_i, got_d}, 64'h2);
    chk("t1_rdata", bus.i_rdata, 64'h0001_0002_0003_0004);
    chk("t1_mem_we", 64'(we_cnt), 64'd0);
    bus.i_req = 1'b0;

    // Test 2: D writeback then fill read of the same block
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 14'h0003; bus.d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t2w_latency", 64'(cyc), 64'd5);
    chk("t2w_who", {62'h0, got_i, got_d}, 64'h1);
    chk("t2w_mem_we", 64'(we_cnt), 64'd4);
    bus.d_req = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_wdata = 64'h0;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t2r_latency", 64'(cyc), 64'd5);
    chk("t2r_rdata", bus.d_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t2r_mem_we", 64'(we_cnt), 64'd0);
    bus.d_req = 1'b0;

    // Test 5: reset in the second access cycle aborts
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 14'h0010;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bus.i_req = 1'b0;
    @(negedge clk);
    chk("t5_busy", {63'h0, bus.busy}, 64'h0);
    chk("t5_mem", {62'h0, bus.mem_en, bus.mem_we}, 64'h0);
    chk("t5_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("t5_mem_wdata", bus.mem_wdata, 64'h0);
    chk("t5_rdata", bus.i_rdata | bus.d_rdata, 64'h0);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
    end
    chk("t5_no_ack", 64'(acks), 64'd0);
    bus.i_req = 1'b1; bus.i_addr = 14'h0020;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t5_after_latency", 64'(cyc), 64'd5);
    chk("t5_after_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
    bus.i_req = 1'b0;

    // Test 3: simultaneous requests, D wins first
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 14'h0010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 14'h0003;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t3_first_cyc", 64'(cyc), 64'd5);
    chk("t3_first_who", {62'h0, got_i, got_d}, 64'h1);
    chk("t3_d_rdata", bus.d_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    bus.d_req = 1'b0;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t3_second_cyc", 64'(cyc), 64'd6);
    chk("t3_second_who", {62'h0, got_i, got_d}, 64'h2);
    chk("t3_overlap", {63'h0, overlap}, 64'h0);
    bus.i_req = 1'b0;

    // Test 4: D keeps requesting after its ack, I must win the next grant
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 14'h0020;
    bus.d_req = 1'b1; bus.d_addr = 14'h0003;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t4_first_who", {62'h0, got_i, got_d}, 64'h1);
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t4_second_cyc", 64'(cyc), 64'd6);
    chk("t4_second_who", {62'h0, got_i, got_d}, 64'h2);
    chk("t4_i_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
    bus.i_req = 1'b0;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t4_third_cyc", 64'(cyc), 64'd6);
    chk("t4_third_who", {62'h0, got_i, got_d}, 64'h1);
    bus.d_req = 1'b0;

    // I read so that D was not the last served before the withdrawal test
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 14'h0010;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t6_pre_who", {62'h0, got_i, got_d}, 64'h2);
    bus.i_req = 1'b0;

    // Test 6: D withdraws during its access
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 14'h0003;
    @(negedge clk);
    @(negedge clk);
    bus.d_req = 1'b0;
    acks = 0; busy5 = 1'b0; busy6 = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
      if (k == 5) busy5 = bus.busy;
      if (k == 6) busy6 = bus.busy;
    end
    chk("t6_no_ack", 64'(acks), 64'd0);
    chk("t6_busy_resp", {63'h0, busy5}, 64'h1);
    chk("t6_busy_idle", {63'h0, busy6}, 64'h0);
    // last_d must still be 0, so D wins a simultaneous request
    bus.i_req = 1'b1; bus.i_addr = 14'h0020;
    bus.d_req = 1'b1;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t6_last_d_who", {62'h0, got_i, got_d}, 64'h1);
    chk("t6_last_d_cyc", 64'(cyc), 64'd5);
    bus.d_req = 1'b0;
    wait_ack(cyc, got_i, got_d, we_cnt, overlap);
    chk("t6_then_i", {62'h0, got_i, got_d}, 64'h2);
    bus.i_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
